// File: rtl/hps_reset_req_sequencer_if.sv
// Request/acknowledge bundle between the reset request sources, the
// sequencer and the SoC f2h reset-request ports.
interface hps_reset_req_sequencer_if;
  logic [2:0] req_in;
  logic       hps_rst_ack;
  logic       cold_req_n;
  logic       warm_req_n;
  logic       debug_req_n;
  logic       busy;
  logic [1:0] last_cause;
  logic       ack_timeout;

  modport master (
    output req_in, hps_rst_ack,
    input  cold_req_n, warm_req_n, debug_req_n, busy, last_cause, ack_timeout
  );

  modport slave (
    input  req_in, hps_rst_ack,
    output cold_req_n, warm_req_n, debug_req_n, busy, last_cause, ack_timeout
  );
endinterface

// File: rtl/hps_reset_req_sequencer.sv
// HPS cold/warm/debug reset request arbiter and pulse sequencer.
// Define HPS_RST_SEQ_RETRY_EN to re-pulse once before flagging an ack timeout.
module hps_reset_req_sequencer #(
  parameter int unsigned COLD_PULSE  = 6,
  parameter int unsigned WARM_PULSE  = 2,
  parameter int unsigned DEBUG_PULSE = 32,
  parameter int unsigned ACK_TIMEOUT = 1000000,
  parameter int unsigned HOLDOFF     = 100000,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input logic                      clk,
  input logic                      rst_n,
  hps_reset_req_sequencer_if.slave bus
);

  // state | meaning: IDLE wait/grant | ASSERT req_n low | WAIT_ACK await ack
  //   | WAIT_REL await ack release | HOLDOFF enforced gap before next grant
  typedef enum logic [2:0] {S_IDLE, S_ASSERT, S_WAIT_ACK, S_WAIT_REL, S_HOLDOFF} state_t;

  localparam logic [7:0]           COLD_W   = 8'(COLD_PULSE);
  localparam logic [7:0]           WARM_W   = 8'(WARM_PULSE);
  localparam logic [7:0]           DEBUG_W  = 8'(DEBUG_PULSE);
  localparam logic [CNT_WIDTH-1:0] ACK_LAST = CNT_WIDTH'(ACK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLDOFF - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t               state;
  logic                 ack_meta, ack_s, ack_d;
  logic [2:0]           req_d;
  logic                 edge_arm;
  logic [2:0]           pending;
  logic [1:0]           cause;
  logic [1:0]           last_cause_q;
  logic [7:0]           pulse_cnt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [2:0]           req_n_q;
  logic                 busy_q;
  logic                 timeout_q;
`ifdef HPS_RST_SEQ_RETRY_EN
  logic                 retried;
`endif

  logic [2:0] rise;
  logic [1:0] grant_cause;
  logic [2:0] grant_clear;

  function automatic logic [7:0] pulse_of(input logic [1:0] c);
    case (c)
      2'd1:    pulse_of = COLD_W;
      2'd2:    pulse_of = WARM_W;
      default: pulse_of = DEBUG_W;
    endcase
  endfunction

  function automatic logic [2:0] low_vec(input logic [1:0] c);
    case (c)
      2'd1:    low_vec = 3'b110;
      2'd2:    low_vec = 3'b101;
      default: low_vec = 3'b011;
    endcase
  endfunction

  // edge_arm masks the first cycle after reset so a level held through reset is not a request
  assign rise = bus.req_in & ~req_d & {3{edge_arm}};

  always_comb begin
    grant_cause = 2'd0;
    grant_clear = 3'b000;
    if (pending[0]) begin
      grant_cause = 2'd1;
      grant_clear = 3'b111;
    end else if (pending[1]) begin
      grant_cause = 2'd2;
      grant_clear = 3'b110;
    end else if (pending[2]) begin
      grant_cause = 2'd3;
      grant_clear = 3'b100;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ack_meta     <= 1'b0;
      ack_s        <= 1'b0;
      ack_d        <= 1'b0;
      req_d        <= 3'b000;
      edge_arm     <= 1'b0;
      pending      <= 3'b000;
      cause        <= 2'd0;
      last_cause_q <= 2'd0;
      pulse_cnt    <= 8'd0;
      cnt          <= '0;
      req_n_q      <= 3'b111;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef HPS_RST_SEQ_RETRY_EN
      retried      <= 1'b0;
`endif
    end else begin
      ack_meta <= bus.hps_rst_ack;
      ack_s    <= ack_meta;
      ack_d    <= ack_s;
      req_d    <= bus.req_in;
      edge_arm <= 1'b1;
      pending  <= pending | rise;
      case (state)
        S_IDLE: begin
          if (|pending) begin
            pending      <= (pending | rise) & ~grant_clear;
            cause        <= grant_cause;
            last_cause_q <= grant_cause;
            pulse_cnt    <= pulse_of(grant_cause);
            busy_q       <= 1'b1;
            state        <= S_ASSERT;
`ifdef HPS_RST_SEQ_RETRY_EN
            retried      <= 1'b0;
`endif
          end
        end
        S_ASSERT: begin
          if (pulse_cnt != 8'd0) begin
            req_n_q   <= low_vec(cause);
            pulse_cnt <= pulse_cnt - 8'd1;
          end else begin
            req_n_q <= 3'b111;
            cnt     <= '0;
            state   <= (cause == 2'd3) ? S_HOLDOFF : S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (ack_s) begin
            state <= S_WAIT_REL;
          end else if (cnt == ACK_LAST) begin
`ifdef HPS_RST_SEQ_RETRY_EN
            if (!retried) begin
              retried   <= 1'b1;
              pulse_cnt <= pulse_of(cause);
              state     <= S_ASSERT;
            end else begin
              timeout_q <= 1'b1;
              cnt       <= '0;
              state     <= S_HOLDOFF;
            end
`else
            timeout_q <= 1'b1;
            cnt       <= '0;
            state     <= S_HOLDOFF;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_WAIT_REL: begin
          if (!ack_s) begin
            cnt   <= '0;
            state <= S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          if (ack_s && !ack_d) begin
            cnt <= '0;
          end else if (cnt == HOLD_LAST) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cold_req_n  = req_n_q[0];
  assign bus.warm_req_n  = req_n_q[1];
  assign bus.debug_req_n = req_n_q[2];
  assign bus.busy        = busy_q;
  assign bus.last_cause  = last_cause_q;
  assign bus.ack_timeout = timeout_q;

endmodule
